// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and decode helpers for the ALU execute stage.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_MUL = 3'b100;
  localparam logic [OP_W-1:0] OP_DIV = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ITER = 2'd2,
    FIN  = 2'd3
  } state_t;

  // True for the ops that run on the multi-cycle multiply/divide datapath.
  function automatic logic is_iter_op(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_exec_unit_iter_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one bit per cycle.
module iter_muldiv #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opd;
  logic             div_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH-1:0] div_diff;

  // High while the last iteration is being applied at the coming edge.
  assign fin = busy && (cnt == '0);

  // One step of each datapath; lo holds multiplier / dividend bits, hi the accumulator / remainder.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, opd});
    div_diff  = div_shift[WIDTH-1:0] - opd;
  end

  // Operand load on go, then WIDTH iterations counted down to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      lo    <= '0;
      hi    <= '0;
      opd   <= '0;
      div_q <= 1'b0;
    end else if (go) begin
      busy  <= 1'b1;
      cnt   <= CNT_W'(WIDTH - 1);
      lo    <= a;
      hi    <= '0;
      opd   <= b;
      div_q <= is_div;
    end else if (busy) begin
      if (div_q) begin
        hi <= div_fits ? div_diff : div_shift[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], div_fits};
      end else begin
        {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
      end
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle adder/logic ops and iterative MUL/DIV behind a start/ready/done handshake.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op_select,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             div_by_zero
);

  state_t           state;
  state_t           state_next;
  logic [2:0]       op_q;
  logic             sub_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             accept;
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] res_n;
  logic [WIDTH-1:0] hi_n;
  logic             carry_n;
  logic             dbz_n;
  logic [WIDTH:0]   add_sum;
  logic             md_busy;
  logic             md_fin;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;

  assign accept  = start && ready;
  // Divide by zero bypasses the iterator and finishes through EXEC.
  assign go      = accept && is_iter_op(op_select) && !((op_select == OP_DIV) && (b == '0));
  assign add_sum = {1'b0, a_q} + {1'b0, b_q ^ {WIDTH{sub_q}}} + (WIDTH + 1)'(sub_q);

  iter_muldiv #(.WIDTH(WIDTH)) u_iter_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .is_div (op_select == OP_DIV),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .fin    (md_fin),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  // Next state and the values loaded into the output registers on completion.
  always_comb begin
    state_next = state;
    finish     = 1'b0;
    res_n      = '0;
    hi_n       = '0;
    carry_n    = 1'b0;
    dbz_n      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = go ? ITER : EXEC;
      end
      EXEC: begin
        finish     = 1'b1;
        state_next = IDLE;
        case (op_q)
          OP_AND: res_n = a_q & b_q;
          OP_OR:  res_n = a_q | b_q;
          OP_DIV: begin
            res_n = '1;
            hi_n  = a_q;
            dbz_n = 1'b1;
          end
          default: begin
            res_n   = add_sum[WIDTH-1:0];
            carry_n = add_sum[WIDTH];
          end
        endcase
      end
      ITER: begin
        if (md_fin) state_next = FIN;
      end
      FIN: begin
        finish     = 1'b1;
        state_next = IDLE;
        res_n      = md_lo;
        hi_n       = md_hi;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, operand capture on accept, and outputs that change only on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      op_q        <= '0;
      sub_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      state <= state_next;
      ready <= (state_next == IDLE);
      done  <= finish;
      if (accept) begin
        op_q  <= op_select;
        sub_q <= sub;
        a_q   <= a;
        b_q   <= b;
      end
      if (finish) begin
        result      <= res_n;
        result_hi   <= hi_n;
        carry       <= carry_n;
        zero        <= (res_n == '0);
        div_by_zero <= dbz_n;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expectations queued on accept, checked on done.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         dbz;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op_select = 3'b000;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry;
  logic         zero;
  logic         div_by_zero;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  bit           hold_en = 1'b0;
  logic         prev_done = 1'b0;
  logic [W-1:0] last_res = '0;
  logic [W-1:0] last_hi = '0;
  exp_t         q[$];

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op_select   (op_select),
    .sub         (sub),
    .a           (a),
    .b           (b),
    .ready       (ready),
    .done        (done),
    .result      (result),
    .result_hi   (result_hi),
    .carry       (carry),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference behaviour of one operation, independent of the RTL structure.
  function automatic exp_t model(input logic [2:0] op, input logic s,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    logic [W:0]  t;
    logic [31:0] p;
    e.res = '0; e.hi = '0; e.c = 1'b0; e.dbz = 1'b0; e.due = 1;
    case (op)
      3'b010: e.res = x & y;
      3'b011: e.res = x | y;
      3'b100: begin
        p = 32'(x) * 32'(y);
        e.res = p[15:0];
        e.hi = p[31:16];
        e.due = W + 1;
      end
      3'b101: begin
        if (y == 0) begin
          e.res = 16'hFFFF;
          e.hi = x;
          e.dbz = 1'b1;
        end else begin
          e.res = x / y;
          e.hi = x % y;
          e.due = W + 1;
        end
      end
      default: begin
        t = {1'b0, x} + {1'b0, y ^ {W{s}}} + 17'(s);
        e.res = t[W-1:0];
        e.c = t[W];
      end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Drive one request, wait for acceptance, queue its expectation, then scramble inputs.
  task automatic issue(input logic [2:0] op, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   n;
    @(negedge clk);
    op_select = op; sub = s; a = x; b = y; start = 1'b1;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("accept_timeout", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    e = model(op, s, x, y);
    e.due = cyc + e.due;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op_select = 3'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_res"}, 32'(result), 32'd0);
    chk({tag, "_hi"}, 32'(result_hi), 32'd0);
    chk({tag, "_flags"}, {29'd0, carry, zero, div_by_zero}, 32'd0);
  endtask

  // Output monitor: scoreboard pop on done, hold check otherwise.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (done) begin
      chk("pulse_len", 32'(prev_done), 32'd0);
      chk("ready_at_done", 32'(ready), 32'd1);
      if (q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        e = q.pop_front();
        chk("latency", 32'(cyc), 32'(e.due));
        chk("result", 32'(result), 32'(e.res));
        chk("result_hi", 32'(result_hi), 32'(e.hi));
        chk("carry", 32'(carry), 32'(e.c));
        chk("zero", 32'(zero), 32'(e.z));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        last_res = e.res;
        last_hi = e.hi;
      end
    end else if (hold_en) begin
      chk("hold_res", 32'(result), 32'(last_res));
      chk("hold_hi", 32'(result_hi), 32'(last_hi));
    end
    prev_done = done;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    rst_n = 1'b1;
    hold_en = 1'b1;

    // Adder: wrap to zero with carry, subtraction with and without borrow.
    issue(OP_ADD, 1'b0, 16'hFFFF, 16'h0001);
    wait_idle();
    issue(OP_SUB, 1'b1, 16'h0005, 16'h0007);
    issue(OP_SUB, 1'b1, 16'h0007, 16'h0005);
    issue(OP_SUB, 1'b0, 16'h0005, 16'h0007);
    issue(3'b110, 1'b0, 16'h1000, 16'h0234);
    issue(3'b111, 1'b1, 16'h4321, 16'h4321);
    issue(OP_AND, 1'b1, 16'hF0F0, 16'h0FF0);
    issue(OP_OR, 1'b1, 16'h0000, 16'h0000);
    wait_idle();

    // Multiply: busy window, full-width product, zero flag from low half only.
    issue(OP_MUL, 1'b0, 16'h0123, 16'h0100);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("busy_ready", 32'(ready), 32'd0);
    end
    wait_idle();
    issue(OP_MUL, 1'b0, 16'hFFFF, 16'hFFFF);
    issue(OP_MUL, 1'b1, 16'h0100, 16'h0100);
    wait_idle();

    // Divide: normal, by zero, flag clearing, zero quotient, divide by one.
    issue(OP_DIV, 1'b0, 16'h0064, 16'h0007);
    issue(OP_DIV, 1'b0, 16'h1234, 16'h0000);
    issue(OP_DIV, 1'b0, 16'h0003, 16'h0007);
    issue(OP_DIV, 1'b0, 16'hFFFF, 16'h0001);
    issue(OP_DIV, 1'b0, 16'h0000, 16'h0000);
    issue(OP_ADD, 1'b0, 16'h0001, 16'h0001);
    wait_idle();

    // Start while busy is dropped.
    issue(OP_MUL, 1'b0, 16'h0003, 16'h0005);
    repeat (4) @(negedge clk);
    op_select = OP_ADD; a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset mid-multiply aborts with no done.
    issue(OP_MUL, 1'b0, 16'h0ABC, 16'h0DEF);
    repeat (7) @(negedge clk);
    hold_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_cleared("abort");
    q.delete();
    last_res = '0;
    last_hi = '0;
    rst_n = 1'b1;
    hold_en = 1'b1;
    repeat (25) @(negedge clk);

    // Back-to-back logic ops.
    issue(OP_AND, 1'b0, 16'h00FF, 16'h0F0F);
    issue(OP_OR, 1'b0, 16'h00FF, 16'h0F0F);
    wait_idle();

    // Random mix.
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] rb;
      rb = (i % 6 == 5) ? 16'h0000 : W'($urandom);
      issue(3'($urandom_range(0, 7)), 1'($urandom), W'($urandom), rb);
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
